// File: rtl/chipmunk_pkg.sv
// chipmunk_pkg: shared constants and loader state encoding for the Chipmunk
// program loader and core.
//   ADDR_W / DATA_W : memory address / data widths (match the core buses)
//   SYNC            : frame sync byte
//   loader_state_t  : loader FSM states; CHK and ERROR exist only when
//                     CHIPMUNK_LOADER_CHECKSUM_EN is defined.
package chipmunk_pkg;
  localparam int unsigned ADDR_W = 12;
  localparam int unsigned DATA_W = 8;
  localparam logic [DATA_W-1:0] SYNC = 8'hA5;

`ifdef CHIPMUNK_LOADER_CHECKSUM_EN
  typedef enum logic [3:0] {
    ST_IDLE, ST_LEN_HI, ST_LEN_LO, ST_ADDR_HI, ST_ADDR_LO,
    ST_DATA, ST_CHK, ST_DRAIN, ST_RUN, ST_ERROR
  } loader_state_t;
`else
  typedef enum logic [3:0] {
    ST_IDLE, ST_LEN_HI, ST_LEN_LO, ST_ADDR_HI, ST_ADDR_LO,
    ST_DATA, ST_DRAIN, ST_RUN
  } loader_state_t;
`endif
endpackage

// File: rtl/chipmunk_loader_if.sv
// chipmunk_loader_if: host byte-stream link into the loader.
//   inByte  : stream byte (host -> loader)
//   inValid : inByte valid (host -> loader)
//   inReady : loader accepts when inValid & inReady at a rising edge
// Modports: master = host side, slave = loader side.
interface chipmunk_loader_if;
  import chipmunk_pkg::*;
  logic [DATA_W-1:0] inByte;
  logic              inValid;
  logic              inReady;

  modport master (output inByte, output inValid, input inReady);
  modport slave  (input inByte, input inValid, output inReady);
endinterface

// File: rtl/chipmunk_bus_mux.sv
// chipmunk_bus_mux: combinational memory-port select.
//   run = 1 : memory driven by the CPU (cpu_addr/cpu_data/cpu_we)
//   run = 0 : memory driven by the loader registers (ldr_*)
module chipmunk_bus_mux
  import chipmunk_pkg::*;
(
  input  logic              run,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_data,
  input  logic              ldr_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_data,
  input  logic              cpu_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_we
);
  always_comb begin
    mem_addr = ldr_addr;
    mem_data = ldr_data;
    mem_we   = ldr_we;
    if (run) begin
      mem_addr = cpu_addr;
      mem_data = cpu_data;
      mem_we   = cpu_we;
    end
  end
endmodule

// File: rtl/chipmunk_loader.sv
// chipmunk_loader: program loader and memory-bus arbiter for the Chipmunk CPU.
// Parses SYNC, LEN_HI, LEN_LO, ADDR_HI, ADDR_LO, payload [, CHK] from the host
// stream, writes the payload to program memory, then releases the CPU at
// startPC and hands it the memory port until cpuDone.
// Ports:
//   clk, reset        : clock, synchronous active-low reset
//   host (slave)      : inByte/inValid/inReady stream
//   cpuAddr/cpuDataWrite/cpuWe/cpuDone : CPU bus inputs
//   memAddr/memData/memWe : memory port (CPU pass-through in RUN)
//   cpuReset          : 0 holds the CPU in reset
//   startPC           : CPU start address (ADDR field of last frame)
//   loading           : frame in progress (LEN_HI .. DRAIN)
//   error             : sticky checksum failure
// Macro CHIPMUNK_LOADER_CHECKSUM_EN adds the CHK byte, ERROR state and error.
module chipmunk_loader
  import chipmunk_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  chipmunk_loader_if.slave    host,
  input  logic [ADDR_W-1:0]   cpuAddr,
  input  logic [DATA_W-1:0]   cpuDataWrite,
  input  logic                cpuWe,
  input  logic                cpuDone,
  output logic [ADDR_W-1:0]   memAddr,
  output logic [DATA_W-1:0]   memData,
  output logic                memWe,
  output logic                cpuReset,
  output logic [ADDR_W-1:0]   startPC,
  output logic                loading,
  output logic                error
);
`ifdef CHIPMUNK_LOADER_CHECKSUM_EN
  localparam loader_state_t ST_POST_DATA = ST_CHK;
`else
  localparam loader_state_t ST_POST_DATA = ST_DRAIN;
`endif

  loader_state_t     state_q, state_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] start_pc_q, start_pc_d;
  logic [3:0]        hi_q, hi_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_data_q, mem_data_d;
  logic              mem_we_q, mem_we_d;
  logic              ready_q, ready_d;
  logic              in_ready;
  logic              accept;
  logic              run;
`ifdef CHIPMUNK_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] sum_q, sum_d;
  logic              error_q, error_d;
`endif

  // ready_q keeps inReady low through the reset cycle itself.
  assign in_ready     = ready_q && (state_q != ST_DRAIN) && (state_q != ST_RUN);
  assign accept       = host.inValid && in_ready;
  assign host.inReady = in_ready;
  assign run          = (state_q == ST_RUN);
  assign cpuReset     = run;
  assign startPC      = start_pc_q;

  always_comb begin
    loading = 1'b1;
    if ((state_q == ST_IDLE) || (state_q == ST_RUN)) loading = 1'b0;
`ifdef CHIPMUNK_LOADER_CHECKSUM_EN
    if (state_q == ST_ERROR) loading = 1'b0;
`endif
  end

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    ptr_d      = ptr_q;
    start_pc_d = start_pc_q;
    hi_d       = hi_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    mem_we_d   = 1'b0;
    ready_d    = 1'b1;
`ifdef CHIPMUNK_LOADER_CHECKSUM_EN
    sum_d      = sum_q;
    error_d    = error_q;
`endif
    unique case (state_q)
      ST_IDLE: if (accept && host.inByte == SYNC) begin
        state_d = ST_LEN_HI;
`ifdef CHIPMUNK_LOADER_CHECKSUM_EN
        sum_d   = '0;
`endif
      end
      ST_LEN_HI: if (accept) begin
        hi_d    = host.inByte[3:0];
        state_d = ST_LEN_LO;
      end
      ST_LEN_LO: if (accept) begin
        len_d   = {hi_q, host.inByte};
        state_d = ST_ADDR_HI;
      end
      ST_ADDR_HI: if (accept) begin
        hi_d    = host.inByte[3:0];
        state_d = ST_ADDR_LO;
      end
      ST_ADDR_LO: if (accept) begin
        ptr_d      = {hi_q, host.inByte};
        start_pc_d = {hi_q, host.inByte};
        state_d    = (len_q == '0) ? ST_POST_DATA : ST_DATA;
      end
      ST_DATA: if (accept) begin
        mem_we_d   = 1'b1;
        mem_addr_d = ptr_q;
        mem_data_d = host.inByte;
        ptr_d      = ptr_q + 12'd1;
        len_d      = len_q - 12'd1;
        if (len_q == 12'd1) state_d = ST_POST_DATA;
      end
`ifdef CHIPMUNK_LOADER_CHECKSUM_EN
      ST_CHK: if (accept) begin
        if (host.inByte == sum_q) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_ERROR;
          error_d = 1'b1;
        end
      end
      ST_ERROR: if (accept && host.inByte == SYNC) begin
        state_d = ST_LEN_HI;
        error_d = 1'b0;
        sum_d   = '0;
      end
`endif
      ST_DRAIN: state_d = ST_RUN;
      ST_RUN:   if (cpuDone) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
`ifdef CHIPMUNK_LOADER_CHECKSUM_EN
    // Checksum covers every accepted byte from LEN_HI through the last payload byte.
    if (accept && (state_q inside {ST_LEN_HI, ST_LEN_LO, ST_ADDR_HI, ST_ADDR_LO, ST_DATA}))
      sum_d = sum_q + host.inByte;
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      ptr_q      <= '0;
      start_pc_q <= '0;
      hi_q       <= '0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      mem_we_q   <= 1'b0;
      ready_q    <= 1'b0;
`ifdef CHIPMUNK_LOADER_CHECKSUM_EN
      sum_q      <= '0;
      error_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      ptr_q      <= ptr_d;
      start_pc_q <= start_pc_d;
      hi_q       <= hi_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      mem_we_q   <= mem_we_d;
      ready_q    <= ready_d;
`ifdef CHIPMUNK_LOADER_CHECKSUM_EN
      sum_q      <= sum_d;
      error_q    <= error_d;
`endif
    end
  end

`ifdef CHIPMUNK_LOADER_CHECKSUM_EN
  assign error = error_q;
`else
  assign error = 1'b0;
`endif

  chipmunk_bus_mux u_bus_mux (
    .run      (run),
    .ldr_addr (mem_addr_q),
    .ldr_data (mem_data_q),
    .ldr_we   (mem_we_q),
    .cpu_addr (cpuAddr),
    .cpu_data (cpuDataWrite),
    .cpu_we   (cpuWe),
    .mem_addr (memAddr),
    .mem_data (memData),
    .mem_we   (memWe)
  );
endmodule

// File: tb/tb_chipmunk_loader.sv
// tb_chipmunk_loader: randomized frames against a queue-based write model.
module tb_chipmunk_loader;
  import chipmunk_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] cpuAddr;
  logic [7:0]  cpuDataWrite;
  logic        cpuWe;
  logic        cpuDone;
  logic [11:0] memAddr;
  logic [7:0]  memData;
  logic        memWe;
  logic        cpuReset;
  logic [11:0] startPC;
  logic        loading;
  logic        error;

  chipmunk_loader_if host ();

  chipmunk_loader dut (
    .clk          (clk),
    .reset        (reset),
    .host         (host),
    .cpuAddr      (cpuAddr),
    .cpuDataWrite (cpuDataWrite),
    .cpuWe        (cpuWe),
    .cpuDone      (cpuDone),
    .memAddr      (memAddr),
    .memData      (memData),
    .memWe        (memWe),
    .cpuReset     (cpuReset),
    .startPC      (startPC),
    .loading      (loading),
    .error        (error)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Model: every payload byte must appear as exactly one write {addr, data}, in order.
  logic [19:0] exp_q[$];
  bit          mon_en = 1'b1;
  logic [7:0]  pl [4096];

  always @(negedge clk) begin
    if (mon_en && memWe === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_eq("wr_unexpected", 32'(memWe), 32'd0);
      end else begin
        logic [19:0] e;
        e = exp_q.pop_front();
        check_eq("wr_addr", 32'(memAddr), 32'(e[19:8]));
        check_eq("wr_data", 32'(memData), 32'(e[7:0]));
      end
    end
  end

  task automatic check_reset_outputs();
    check_eq("rst_inReady",  32'(host.inReady), 32'd0);
    check_eq("rst_memWe",    32'(memWe),        32'd0);
    check_eq("rst_memAddr",  32'(memAddr),      32'd0);
    check_eq("rst_memData",  32'(memData),      32'd0);
    check_eq("rst_cpuReset", 32'(cpuReset),     32'd0);
    check_eq("rst_startPC",  32'(startPC),      32'd0);
    check_eq("rst_loading",  32'(loading),      32'd0);
    check_eq("rst_error",    32'(error),        32'd0);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stall);
    int gap;
    gap = stall ? int'($urandom_range(0, 2)) : 0;
    repeat (gap) begin
      @(negedge clk);
      host.inValid = 1'b0;
      host.inByte  = 8'($urandom);
    end
    @(negedge clk);
    host.inByte  = b;
    host.inValid = 1'b1;
    check_eq("in_ready", 32'(host.inReady), 32'd1);
    @(posedge clk);
  endtask

  task automatic send_garbage(input int n);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom);
      if (b == SYNC) b = 8'h00;
      send_byte(b, 1'b1);
    end
  endtask

  // Sends one frame using pl[0..len-1]; returns with the loader back in IDLE
  // (or in ERROR when bad_chk is set and the checksum is enabled).
  task automatic run_frame(input int len, input logic [11:0] addr, input bit stall,
                           input bit rand_nib, input bit bad_chk, input bit passthru);
    logic [7:0]  sum;
    logic [7:0]  hdr [4];
    logic [3:0]  n0, n1;
    logic [11:0] len12;
    bit          to_error;
    len12 = 12'(len);
    n0 = rand_nib ? 4'($urandom_range(0, 15)) : 4'h0;
    n1 = rand_nib ? 4'($urandom_range(0, 15)) : 4'h0;
    hdr[0] = {n0, len12[11:8]};
    hdr[1] = len12[7:0];
    hdr[2] = {n1, addr[11:8]};
    hdr[3] = addr[7:0];
    sum = 8'h00;
    to_error = 1'b0;
`ifdef CHIPMUNK_LOADER_CHECKSUM_EN
    to_error = bad_chk;
`endif
    send_byte(SYNC, stall);
    @(negedge clk);
    host.inValid = 1'b0;
    check_eq("sync_error_clear", 32'(error),   32'd0);
    check_eq("sync_loading",     32'(loading), 32'd1);
    for (int i = 0; i < 4; i++) begin
      send_byte(hdr[i], stall);
      sum = sum + hdr[i];
    end
    for (int i = 0; i < len; i++) begin
      exp_q.push_back({addr + 12'(i), pl[i]});
      send_byte(pl[i], stall);
      sum = sum + pl[i];
    end
`ifdef CHIPMUNK_LOADER_CHECKSUM_EN
    send_byte(bad_chk ? sum + 8'h01 : sum, stall);
`endif
    @(negedge clk);
    host.inValid = 1'b0;
    if (to_error) begin
      check_eq("err_flag",     32'(error),        32'd1);
      check_eq("err_cpuReset", 32'(cpuReset),     32'd0);
      check_eq("err_inReady",  32'(host.inReady), 32'd1);
      check_eq("err_loading",  32'(loading),      32'd0);
      check_eq("err_writes",   32'(exp_q.size()), 32'd0);
      send_garbage(2);
      repeat (2) @(negedge clk);
      host.inValid = 1'b0;
      check_eq("err_sticky",   32'(error),        32'd1);
      check_eq("err_held",     32'(cpuReset),     32'd0);
    end else begin
      check_eq("drain_cpuReset", 32'(cpuReset),     32'd0);
      check_eq("drain_inReady",  32'(host.inReady), 32'd0);
      check_eq("drain_loading",  32'(loading),      32'd1);
      @(negedge clk);
      check_eq("run_cpuReset", 32'(cpuReset),     32'd1);
      check_eq("run_inReady",  32'(host.inReady), 32'd0);
      check_eq("run_loading",  32'(loading),      32'd0);
      check_eq("run_startPC",  32'(startPC),      32'(addr));
      check_eq("run_writes",   32'(exp_q.size()), 32'd0);
      if (passthru) begin
        #1;
        mon_en       = 1'b0;
        cpuAddr      = 12'h050;
        cpuDataWrite = 8'h42;
        cpuWe        = 1'b1;
        #1;
        check_eq("pass_addr", 32'(memAddr), 32'h050);
        check_eq("pass_data", 32'(memData), 32'h42);
        check_eq("pass_we",   32'(memWe),   32'd1);
        cpuWe = 1'b0;
        #1;
        check_eq("pass_we_off", 32'(memWe), 32'd0);
        mon_en = 1'b1;
        @(negedge clk);
      end
      cpuDone = 1'b1;
      @(negedge clk);
      cpuDone = 1'b0;
      check_eq("done_cpuReset", 32'(cpuReset),     32'd0);
      check_eq("done_inReady",  32'(host.inReady), 32'd1);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int len;
    reset        = 1'b0;
    host.inByte  = 8'h00;
    host.inValid = 1'b0;
    cpuAddr      = 12'h000;
    cpuDataWrite = 8'h00;
    cpuWe        = 1'b0;
    cpuDone      = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    reset = 1'b1;
    @(negedge clk);
    check_eq("ready_after_reset", 32'(host.inReady), 32'd1);

    // Frame A: 11 22 33 at 0x010, no stalls, then CPU bus pass-through.
    pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33;
    run_frame(3, 12'h010, 1'b0, 1'b0, 1'b0, 1'b1);

    // Garbage (with cpuWe asserted outside RUN) then a valid frame.
    cpuWe = 1'b1; cpuAddr = 12'h3C3; cpuDataWrite = 8'h99;
    send_byte(8'h00, 1'b0);
    send_byte(8'hFF, 1'b0);
    send_byte(8'h5A, 1'b0);
    @(negedge clk);
    host.inValid = 1'b0;
    check_eq("garbage_loading", 32'(loading), 32'd0);
    cpuWe = 1'b0;
    pl[0] = 8'h5C; pl[1] = 8'hE7;
    run_frame(2, 12'h200, 1'b1, 1'b0, 1'b0, 1'b0);

    // Address wrap 0xFFF -> 0x000.
    pl[0] = 8'hAA; pl[1] = 8'hBB;
    run_frame(2, 12'hFFF, 1'b0, 1'b0, 1'b0, 1'b0);

    // Zero-length frame.
    run_frame(0, 12'h123, 1'b0, 1'b0, 1'b0, 1'b0);

    // Length using the LEN_HI field.
    for (int i = 0; i < 258; i++) pl[i] = 8'($urandom);
    run_frame(258, 12'(12'hF80), 1'b1, 1'b1, 1'b0, 1'b0);

`ifdef CHIPMUNK_LOADER_CHECKSUM_EN
    // Wrong checksum, then recovery by a fresh frame.
    pl[0] = 8'h01; pl[1] = 8'h02; pl[2] = 8'h03;
    run_frame(3, 12'h300, 1'b0, 1'b0, 1'b1, 1'b0);
    pl[0] = 8'h44;
    run_frame(1, 12'h301, 1'b1, 1'b0, 1'b0, 1'b0);
`endif

    // Reset mid-DATA: two of five payload bytes land, the rest is discarded.
    send_byte(SYNC, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h05, 1'b0);
    send_byte(8'h04, 1'b0);
    send_byte(8'h40, 1'b0);
    exp_q.push_back({12'h440, 8'hD1});
    send_byte(8'hD1, 1'b0);
    exp_q.push_back({12'h441, 8'hD2});
    send_byte(8'hD2, 1'b0);
    @(negedge clk);
    host.inValid = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    check_reset_outputs();
    check_eq("mid_rst_writes", 32'(exp_q.size()), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check_eq("mid_rst_ready", 32'(host.inReady), 32'd1);

    // Randomized frames with garbage prefixes and input stalls.
    for (int f = 0; f < 20; f++) begin
      send_garbage(int'($urandom_range(0, 3)));
      len = int'($urandom_range(0, 10));
      for (int i = 0; i < len; i++) pl[i] = 8'($urandom);
`ifdef CHIPMUNK_LOADER_CHECKSUM_EN
      run_frame(len, 12'($urandom), 1'b1, 1'b1, ($urandom_range(0, 4) == 0), 1'b0);
`else
      run_frame(len, 12'($urandom), 1'b1, 1'b1, 1'b0, 1'b0);
`endif
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
